// File: rtl/fetch_unit.sv
// fetch_unit -- instruction fetch stage feeding the main decoder.
//
// Holds the PC and sends word requests to instruction memory over a
// req/gnt/rvalid handshake. Returned words go into a small in-order FIFO
// of {pc, instr} entries. The FIFO head is offered to the decoder with a
// valid/ready handshake. A redirect from execute flushes the FIFO, reloads
// the PC and marks every in-flight response to be dropped.
//
// Parameters:
//   RESET_PC  PC loaded on reset (word aligned)
//   DEPTH     FIFO entries, also the outstanding-request credit limit (2 or 4)
//
// Ports:
//   clk_i, rst_n_i              clock, synchronous active-low reset
//   imem_req_o, imem_addr_o     request valid / word address (equals the PC)
//   imem_gnt_i                  request accepted this cycle
//   imem_rvalid_i, imem_rdata_i in-order response valid / instruction word
//   redirect_i, redirect_pc_i   taken branch/jump pulse and its target
//   valid_o, ready_i            head valid / decoder accepts head
//   instr_o, pc_o, op_o         head instruction, its PC, opcode bits [6:0]
//   misaligned_o                sticky misaligned-redirect flag
//
// Build option:
//   FETCH_MISALIGN_TRAP_EN  when defined, a redirect to a target with
//   non-zero low bits flushes but does not load the PC, and sets the sticky
//   misaligned_o flag, which halts fetch until reset or an aligned redirect.
//   When undefined, the low target bits are ignored and misaligned_o is 0.

module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          DEPTH    = 2
) (
  input  logic        clk_i,
  input  logic        rst_n_i,
  output logic        imem_req_o,
  output logic [31:0] imem_addr_o,
  input  logic        imem_gnt_i,
  input  logic        imem_rvalid_i,
  input  logic [31:0] imem_rdata_i,
  input  logic        redirect_i,
  input  logic [31:0] redirect_pc_i,
  output logic        valid_o,
  input  logic        ready_i,
  output logic [31:0] instr_o,
  output logic [31:0] pc_o,
  output logic [6:0]  op_o,
  output logic        misaligned_o
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);
  localparam logic [CW:0]   CREDIT_LIMIT = DEPTH[CW:0];
  localparam logic [CW-1:0] FULL_COUNT   = DEPTH[CW-1:0];

  logic [31:0]   pc_reg, pc_next;
  logic [31:0]   resp_pc_reg, resp_pc_next;   // PC of the next response to be kept
  logic [CW-1:0] count_reg, count_next;
  logic [CW-1:0] outstanding_reg, outstanding_next;
  logic [CW-1:0] discard_reg, discard_next;
  logic [PW-1:0] rd_ptr_reg, rd_ptr_next;
  logic [PW-1:0] wr_ptr_reg, wr_ptr_next;

  logic          halted;
  logic          redirect_load;
  logic [CW:0]   credit_sum;
  logic          grant;
  logic          push;
  logic          pop;
  logic          head_valid;

  logic [31:0]   entry_instr [DEPTH];
  logic [31:0]   entry_pc    [DEPTH];

`ifdef FETCH_MISALIGN_TRAP_EN
  logic halted_reg, halted_next;
  logic redirect_aligned;

  assign redirect_aligned = (redirect_pc_i[1:0] == 2'b00);
  assign redirect_load    = redirect_i & redirect_aligned;
  assign halted           = halted_reg;
  assign misaligned_o     = halted_reg;

  // A misaligned redirect sets the flag, an aligned one clears it.
  always_comb begin
    halted_next = halted_reg;
    if (redirect_i) begin
      halted_next = !redirect_aligned;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      halted_reg <= 1'b0;
    end else begin
      halted_reg <= halted_next;
    end
  end
`else
  logic unused_redirect_low_bits;

  // Low target bits are forced to zero on load, so they are not needed.
  assign unused_redirect_low_bits = |redirect_pc_i[1:0];
  assign redirect_load = redirect_i;
  assign halted        = 1'b0;
  assign misaligned_o  = 1'b0;
`endif

  // Credits count both buffered words and words still in flight, so a
  // response always finds a free FIFO slot.
  assign credit_sum = {1'b0, count_reg} + {1'b0, outstanding_reg};
  assign imem_req_o = rst_n_i & !redirect_i & !halted & (credit_sum < CREDIT_LIMIT);
  assign imem_addr_o = pc_reg;
  assign grant       = imem_req_o & imem_gnt_i;

  // A response arriving in a redirect cycle belongs to the old stream.
  assign push = imem_rvalid_i & !redirect_i & (discard_reg == '0);

  assign head_valid = (count_reg != '0);
  assign valid_o    = head_valid & !redirect_i;
  assign pop        = valid_o & ready_i;

  assign instr_o = head_valid ? entry_instr[rd_ptr_reg] : 32'h0;
  assign pc_o    = head_valid ? entry_pc[rd_ptr_reg]    : 32'h0;
  assign op_o    = instr_o[6:0];

  // FIFO storage; entries need no reset because the head is masked when empty.
  genvar gi;
  generate
    for (gi = 0; gi < DEPTH; gi++) begin : g_entry
      logic [31:0] instr_reg;
      logic [31:0] pc_tag_reg;

      always_ff @(posedge clk_i) begin
        if (push && (wr_ptr_reg == PW'(gi))) begin
          instr_reg  <= imem_rdata_i;
          pc_tag_reg <= resp_pc_reg;
        end
      end

      assign entry_instr[gi] = instr_reg;
      assign entry_pc[gi]    = pc_tag_reg;
    end
  endgenerate

  always_comb begin
    pc_next          = pc_reg;
    resp_pc_next     = resp_pc_reg;
    count_next       = count_reg;
    outstanding_next = outstanding_reg;
    discard_next     = discard_reg;
    rd_ptr_next      = rd_ptr_reg;
    wr_ptr_next      = wr_ptr_reg;

    if (redirect_i) begin
      count_next       = '0;
      rd_ptr_next      = '0;
      wr_ptr_next      = '0;
      // No grant is possible here, so only a response can retire.
      outstanding_next = outstanding_reg - CW'(imem_rvalid_i);
      discard_next     = outstanding_next;
      if (redirect_load) begin
        pc_next      = {redirect_pc_i[31:2], 2'b00};
        resp_pc_next = {redirect_pc_i[31:2], 2'b00};
      end
    end else begin
      if (grant) begin
        pc_next = pc_reg + 32'd4;
      end
      outstanding_next = outstanding_reg + CW'(grant) - CW'(imem_rvalid_i);
      if (imem_rvalid_i && (discard_reg != '0)) begin
        discard_next = discard_reg - CW'(1);
      end
      if (push) begin
        wr_ptr_next  = wr_ptr_reg + PW'(1);
        resp_pc_next = resp_pc_reg + 32'd4;
      end
      if (pop) begin
        rd_ptr_next = rd_ptr_reg + PW'(1);
      end
      count_next = count_reg + CW'(push) - CW'(pop);
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      pc_reg          <= RESET_PC;
      resp_pc_reg     <= RESET_PC;
      count_reg       <= '0;
      outstanding_reg <= '0;
      discard_reg     <= '0;
      rd_ptr_reg      <= '0;
      wr_ptr_reg      <= '0;
    end else begin
      pc_reg          <= pc_next;
      resp_pc_reg     <= resp_pc_next;
      count_reg       <= count_next;
      outstanding_reg <= outstanding_next;
      discard_reg     <= discard_next;
      rd_ptr_reg      <= rd_ptr_next;
      wr_ptr_reg      <= wr_ptr_next;
    end
  end

  // The credit scheme must never let a response land in a full FIFO.
  a_no_push_when_full: assert property (
    @(posedge clk_i) disable iff (!rst_n_i) !(push && !pop && (count_reg == FULL_COUNT))
  );

endmodule
